timer_display: RTL
==================

# timer_display

Display-side reader for the stopwatch/countdown `timer` block. It consumes the timer's `sec`/`min`/`hour`/`alarm`/`buzy_n` outputs and drives a 6-digit multiplexed 7-segment display. Once per scan frame it snapshots the count and converts each field to two decimal digits with a sequential divide-by-10 FSM. It latches the alarm and blinks the display until the next run starts.

## Interface
- `WIDTH`, 16: width of `sec`/`min`/`hour`; must match the timer.
- `SCAN_DIV`, 1000: clocks per digit slot; minimum 2.
- `BLINK_FRAMES`, 16: frames per blink half-period while the alarm is latched; minimum 1.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sec`, `min`, `hour`  in  WIDTH each  timer count outputs, unsigned binary.
- `alarm`  in  1  timer end-of-count level; may last only 1 cycle.
- `buzy_n`  in  1  timer idle flag; 0 = running.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-high.
- `an`  out  6  one-hot digit enable, active-high:
  - `an[0]`/`an[1]` = sec units/tens
  - `an[2]`/`an[3]` = min units/tens
  - `an[4]`/`an[5]` = hour units/tens
- `dp`  out  1  decimal point, active-high.
- `ovf`  out  1  a field exceeded 99 in the last committed conversion.

## Operation
- **Prescaler**
  - `pre` counts 0..SCAN_DIV-1.
  - At the terminal count, digit index `dig` advances 0→5 and wraps to 0.
  - Frame tick = terminal count with `dig`==5.
- **Conversion FSM** (states IDLE, LOAD, CONV, DONE)
  - IDLE→LOAD on a pending request. A request is set by a frame tick and is also set out of reset.
  - A frame tick that arrives while not in IDLE is dropped.
  - LOAD (1 cycle): snapshot `sec`/`min`/`hour`. Any field >99 is clamped to 99 and `ovf_next` is set. Field pointer starts at sec.
  - CONV: each cycle, if rem≥10 then rem-=10 and tens+=1. Otherwise store {tens, rem} for the current field and advance the pointer. After hour, go to DONE.
  - DONE (1 cycle): atomically copy all six digits and `ovf_next` into the display registers, then go to IDLE.
  - Latency from LOAD to the display-register update = 2 + Σ(tens_i+1) cycles; maximum 32.
- **Outputs**
  - `seg` = decode of the display digit selected by `dig`: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - `an` = one-hot of `dig`.
  - `dp` = 1 on digits 2 and 4 while `buzy_n`==0; otherwise 0.
- **Alarm latch**
  - Set when `alarm`==1.
  - Cleared on a registered 1→0 edge of `buzy_n`. If set and clear occur together, set wins.
  - While latched, the blink phase toggles every BLINK_FRAMES frame ticks, starting in the off phase.
  - In the off phase, `an`=0 and `seg`=0. `dp` follows the same gating.
  - When the latch clears, the blink phase resets to on.

## Timing
- **Reset values**: `an`=0, `seg`=0, `dp`=0, `ovf`=0, `pre`=0, `dig`=0, display digits=0, latch=0, FSM=IDLE, request=1.
- **After reset release**:
  - First LOAD occurs on the first clock edge.
  - `an`=6'b000001 and `seg`=0x3F from the first edge until the first DONE.
- **Output registers**: `seg`/`an`/`dp` are registered and change 1 clk after `dig` or the display registers change. They never show a partially converted frame.
- **Snapshot rule**: input changes after LOAD do not affect the current conversion.
- **Asynchronous reset mid-conversion**: all outputs go to reset values immediately. The conversion restarts after release.
- **`ovf`**: updates only at DONE and holds for the whole frame.

## Test plan
- **Basic conversion**:
  - Stimulus: reset, hour=12, min=34, sec=56, SCAN_DIV=4.
  - Response: DONE within 32 cycles; scan order gives `seg` 0x7D, 0x6D, 0x66, 0x4F, 0x5B, 0x06 with `an` 000001..100000; `ovf`=0.
- **Clamp and recovery**:
  - Stimulus: hour=100; on the next frame, hour=5.
  - Response: hour digits show 9,9 with `ovf`=1; on the next frame, digits show 0,5 with `ovf`=0.
- **Snapshot atomicity**:
  - Stimulus: sec=59 at LOAD, then sec=0 during CONV.
  - Response: sec digits show 9,5 until the next frame's DONE.
- **Alarm blink**:
  - Stimulus: 1-cycle `alarm` pulse with `buzy_n`=1, BLINK_FRAMES=1.
  - Response: `an`=0 for the current and next full frame, then alternating frames on/off; a `buzy_n` 1→0 edge restores continuous scan and sets `dp` on digits 2 and 4.
- **Simultaneous alarm set and clear**:
  - Stimulus: `alarm`=1 on the same cycle as the `buzy_n` 1→0 edge.
  - Response: latch stays set and the display keeps blinking.
- **Reset mid-CONV**:
  - Stimulus: assert `rst` for 1 cycle during CONV.
  - Response: `an`/`seg`/`dp`/`ovf`=0 asynchronously; a new LOAD occurs on the first edge after release.

Source files
------------

// File: rtl/timer_display_if.sv
// Timer-to-display signal bundle: timer count/status in, multiplexed 7-segment drive out.
interface timer_display_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] sec;
  logic [WIDTH-1:0] min;
  logic [WIDTH-1:0] hour;
  logic             alarm;
  logic             buzy_n;
  logic [6:0]       seg;
  logic [5:0]       an;
  logic             dp;
  logic             ovf;

  modport master (
    output sec, min, hour, alarm, buzy_n,
    input  seg, an, dp, ovf
  );

  modport slave (
    input  sec, min, hour, alarm, buzy_n,
    output seg, an, dp, ovf
  );
endinterface

// File: rtl/timer_display.sv
// Display reader for the timer: per-frame snapshot, sequential binary-to-BCD by
// repeated subtraction, 6-digit scan with alarm blink.
module timer_display #(
  parameter int WIDTH        = 16,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 16
) (
  input  logic           clk,
  input  logic           rst,
  timer_display_if.slave bus
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CONV = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [PW-1:0]    r_pre;
  logic [2:0]       r_dig;
  logic             w_tick;
  logic [1:0]       r_state;
  logic             r_req;
  logic [WIDTH-1:0] w_field [3];
  logic [6:0]       w_clamp [3];
  logic [2:0]       w_big;
  logic [6:0]       r_snap [3];
  logic [6:0]       r_rem;
  logic [3:0]       r_tens;
  logic [1:0]       r_ptr;
  logic [3:0]       r_cdig [6];
  logic [3:0]       r_disp [6];
  logic             r_ovf_next;
  logic             r_ovf;
  logic             r_latch;
  logic             r_phase_on;
  logic             r_blink_sync;
  logic [15:0]      r_blink_cnt;
  logic             r_buzy_prev;
  logic             w_buzy_fall;
  logic             w_blank;
  logic [6:0]       r_seg;
  logic [5:0]       r_an;
  logic             r_dp;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  assign w_field[0] = bus.sec;
  assign w_field[1] = bus.min;
  assign w_field[2] = bus.hour;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_clamp
      assign w_big[gi]   = w_field[gi] > WIDTH'(99);
      assign w_clamp[gi] = w_big[gi] ? 7'd99 : w_field[gi][6:0];
    end
  endgenerate

  assign w_tick      = (r_pre == PW'(SCAN_DIV - 1)) && (r_dig == 3'd5);
  assign w_buzy_fall = r_buzy_prev && !bus.buzy_n;
  assign w_blank     = r_latch && !r_phase_on;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
      r_dig <= 3'd0;
    end else if (r_pre == PW'(SCAN_DIV - 1)) begin
      r_pre <= '0;
      r_dig <= (r_dig == 3'd5) ? 3'd0 : r_dig + 3'd1;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  // Conversion: one field at a time; digits only become visible together at DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b1;
      r_rem      <= 7'd0;
      r_tens     <= 4'd0;
      r_ptr      <= 2'd0;
      r_ovf_next <= 1'b0;
      r_ovf      <= 1'b0;
      for (int i = 0; i < 3; i++) r_snap[i] <= 7'd0;
      for (int i = 0; i < 6; i++) begin
        r_cdig[i] <= 4'd0;
        r_disp[i] <= 4'd0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_req) begin
            r_state <= S_LOAD;
            r_req   <= 1'b0;
          end else if (w_tick) begin
            r_req <= 1'b1;
          end
        end
        S_LOAD: begin
          for (int i = 0; i < 3; i++) r_snap[i] <= w_clamp[i];
          r_ovf_next <= |w_big;
          r_rem      <= w_clamp[0];
          r_tens     <= 4'd0;
          r_ptr      <= 2'd0;
          r_state    <= S_CONV;
        end
        S_CONV: begin
          if (r_rem >= 7'd10) begin
            r_rem  <= r_rem - 7'd10;
            r_tens <= r_tens + 4'd1;
          end else begin
            r_cdig[{r_ptr, 1'b0}] <= r_rem[3:0];
            r_cdig[{r_ptr, 1'b1}] <= r_tens;
            r_tens <= 4'd0;
            if (r_ptr == 2'd2) begin
              r_state <= S_DONE;
            end else begin
              r_ptr <= r_ptr + 2'd1;
              r_rem <= r_snap[r_ptr + 2'd1];
            end
          end
        end
        S_DONE: begin
          for (int i = 0; i < 6; i++) r_disp[i] <= r_cdig[i];
          r_ovf   <= r_ovf_next;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The partial frame in which the alarm latches is not counted toward the first off period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_latch      <= 1'b0;
      r_phase_on   <= 1'b1;
      r_blink_sync <= 1'b0;
      r_blink_cnt  <= 16'd0;
      r_buzy_prev  <= 1'b1;
    end else begin
      r_buzy_prev <= bus.buzy_n;
      if (!r_latch) begin
        if (bus.alarm) begin
          r_latch      <= 1'b1;
          r_phase_on   <= 1'b0;
          r_blink_sync <= 1'b0;
          r_blink_cnt  <= 16'd0;
        end
      end else if (w_buzy_fall && !bus.alarm) begin
        r_latch    <= 1'b0;
        r_phase_on <= 1'b1;
      end else if (w_tick) begin
        if (!r_blink_sync) begin
          r_blink_sync <= 1'b1;
        end else if (r_blink_cnt == 16'(BLINK_FRAMES - 1)) begin
          r_blink_cnt <= 16'd0;
          r_phase_on  <= ~r_phase_on;
        end else begin
          r_blink_cnt <= r_blink_cnt + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg <= 7'd0;
      r_an  <= 6'd0;
      r_dp  <= 1'b0;
    end else begin
      r_seg <= w_blank ? 7'd0 : seg7(r_disp[r_dig]);
      r_an  <= w_blank ? 6'd0 : (6'd1 << r_dig);
      r_dp  <= !w_blank && !bus.buzy_n && ((r_dig == 3'd2) || (r_dig == 3'd4));
    end
  end

  assign bus.seg = r_seg;
  assign bus.an  = r_an;
  assign bus.dp  = r_dp;
  assign bus.ovf = r_ovf;
endmodule
